// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// General-purpose up/down modulo counter for the audio DSP datapath (frame
// index, delay-line pointers, sample counters). Counts over 0..MODULUS-1. At a
// range end it either wraps or holds, depending on SATURATE. It also supports
// a synchronous clear and a parallel load, and emits registered one-cycle
// event flags.
//
// Parameters:
//   WIDTH    : bit width of q (1..32)
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE : 0 = wrap at range ends, 1 = hold at range ends
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   clr      in   synchronous clear to 0 (highest priority)
//   load     in   synchronous parallel load (clamped to MODULUS-1)
//   load_val in   load value [WIDTH-1:0]
//   en       in   count enable (lowest priority)
//   up       in   direction: 1 = increment, 0 = decrement
//   q        out  registered count value [WIDTH-1:0]
//   wrap     out  registered pulse: the last update crossed a range end (wrap mode)
//   sat_hit  out  registered pulse: a count was blocked at a range end (saturate mode)
//   at_max   out  combinational, q == MODULUS-1
//   at_min   out  combinational, q == 0
//   wrap_cnt out  [15:0] saturating count of wrap (or sat_hit) events;
//                 present only when UDC_WRAP_COUNT_EN is defined
//
// Optional feature macro: UDC_WRAP_COUNT_EN
// -----------------------------------------------------------------------------
module updown_mod_counter #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             sat_hit,
    output logic             at_max,
    output logic             at_min
`ifdef UDC_WRAP_COUNT_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    // All range arithmetic is done one bit wider than q. This lets
    // MODULUS == 2**WIDTH be represented exactly and exposes the borrow bit.
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

    logic [WIDTH:0]   q_inc;
    logic [WIDTH:0]   q_dec;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign q_inc = {1'b0, q} + ONE_W;
    assign q_dec = {1'b0, q} - ONE_W;

    // q+1 reaching MODULUS means q is the top of the range. A borrow out of
    // q-1 means q is zero.
    assign at_max = (q_inc == MOD_W);
    assign at_min = q_dec[WIDTH];

    // Next-state decode, priority clr > load > en.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
        q_nxt    = q;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the range.
            q_nxt = ({1'b0, load_val} < MOD_W) ? load_val : MAX_W[WIDTH-1:0];
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_nxt = q_inc[WIDTH-1:0];
                end else if (SATURATE) begin
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    q_nxt = q_dec[WIDTH-1:0];
                end else if (SATURATE) begin
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = MAX_W[WIDTH-1:0];
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // The event flags are registered alongside q, so each pulse appears in
    // the same cycle as the count value it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            q       <= q_nxt;
            wrap    <= wrap_nxt;
            sat_hit <= sat_nxt;
        end
    end

`ifdef UDC_WRAP_COUNT_EN
    // Counts the same events that raise wrap or sat_hit, and sticks at
    // all-ones. The two sources are mutually exclusive by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (clr) begin
            wrap_cnt <= '0;
        end else if ((wrap_nxt || sat_nxt) && (wrap_cnt != 16'hFFFF)) begin
            wrap_cnt <= wrap_cnt + 16'd1;
        end
    end
`endif

endmodule
